// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter
//   Shares the NUM_PORTS modify-entry write ports of the reorder/instruction
//   circular queue among NUM_REQ functional-unit writeback requesters.
//   Round-robin scan, up to NUM_PORTS grants per cycle, same-entry conflicts
//   resolved in scan order, one registered output stage.
//
//   Optional feature (macro ROB_WB_AGE_BOOST_EN): per-requester wait counters
//   saturating at STARVE_LIMIT; saturated requesters are scanned first.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   flush         drop all pending writebacks this cycle
//   req_valid     per-requester request valid
//   req_idx       flattened NUM_REQ x DEPTH_BITS target entry
//   req_data      flattened NUM_REQ x WIDTH update data
//   req_ready     combinational grant (transfer on valid && ready)
//   wr_mask       registered per-port write enable (queue in_bitmask)
//   wr_sel        registered flattened NUM_PORTS x DEPTH_BITS entry select
//   wr_data       registered flattened NUM_PORTS x WIDTH data
//   busy          registered: some valid requester was refused last cycle
module rob_wb_arbiter #(
  parameter int NUM_REQ      = 6,
  parameter int NUM_PORTS    = 4,
  parameter int WIDTH        = 32,
  parameter int DEPTH_BITS   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DEPTH_BITS-1:0]   req_idx,
  input  logic [NUM_REQ*WIDTH-1:0]        req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_PORTS-1:0]            wr_mask,
  output logic [NUM_PORTS*DEPTH_BITS-1:0] wr_sel,
  output logic [NUM_PORTS*WIDTH-1:0]      wr_data,
  output logic                            busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                rr_ptr;
  logic [PTR_W-1:0]                nxt_ptr;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_REQ-1:0]              boosted;
  logic [NUM_PORTS-1:0]            nxt_mask;
  logic [NUM_PORTS*DEPTH_BITS-1:0] nxt_sel;
  logic [NUM_PORTS*WIDTH-1:0]      nxt_data;

`ifdef ROB_WB_AGE_BOOST_EN
  localparam int PASSES = 2;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++)
      boosted[i] = (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rst || flush || grant[i])
        wait_cnt[i] <= '0;
      else if (req_valid[i] && (wait_cnt[i] != CNT_W'(STARVE_LIMIT)))
        wait_cnt[i] <= wait_cnt[i] + 1'b1;
    end
  end
`else
  localparam int PASSES = 1;

  assign boosted = '0;
`endif

  // Pass 0 takes only boosted requesters (boost build), the last pass takes
  // the rest; within a pass the order is rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  // nxt_sel doubles as the list of entries already claimed this cycle.
  always_comb begin
    int unsigned r;
    int unsigned n;
    int unsigned last;
    logic        conflict;
    logic        take;

    grant    = '0;
    nxt_mask = '0;
    nxt_sel  = wr_sel;
    nxt_data = wr_data;
    nxt_ptr  = rr_ptr;
    n        = 0;
    last     = 0;
    r        = 0;
    conflict = 1'b0;
    take     = 1'b0;

    if (!rst && !flush) begin
      for (int unsigned p = 0; p < PASSES; p++) begin
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
          r = 32'(rr_ptr) + j;
          if (r >= NUM_REQ) r = r - NUM_REQ;
          take = req_valid[r] && !grant[r] &&
                 ((PASSES == 1) || (boosted[r] == (p == 0)));
          conflict = 1'b0;
          for (int unsigned k = 0; k < NUM_PORTS; k++)
            if ((k < n) && (nxt_sel[k*DEPTH_BITS +: DEPTH_BITS] ==
                            req_idx[r*DEPTH_BITS +: DEPTH_BITS]))
              conflict = 1'b1;
          if (take && !conflict && (n < NUM_PORTS)) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
              if (k == n) begin
                nxt_mask[k]                          = 1'b1;
                nxt_sel[k*DEPTH_BITS +: DEPTH_BITS]  = req_idx[r*DEPTH_BITS +: DEPTH_BITS];
                nxt_data[k*WIDTH +: WIDTH]           = req_data[r*WIDTH +: WIDTH];
              end
            end
            grant[r] = 1'b1;
            last     = r;
            n        = n + 1;
          end
        end
      end
      if (n != 0)
        nxt_ptr = (last == NUM_REQ - 1) ? '0 : PTR_W'(last + 1);
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      wr_mask <= '0;
      wr_sel  <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      rr_ptr  <= nxt_ptr;
      wr_mask <= nxt_mask;
      wr_sel  <= nxt_sel;
      wr_data <= nxt_data;
      busy    <= flush ? 1'b0 : |(req_valid & ~grant);
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Testbench for rob_wb_arbiter: directed scenarios followed by randomized
// traffic, checked by a queue-based reference model and a decoupled monitor.
module tb_rob_wb_arbiter;

  localparam int NR = 6;
  localparam int NP = 4;
  localparam int W  = 32;
  localparam int DB = 4;
`ifdef ROB_WB_AGE_BOOST_EN
  localparam int SL    = 2;
  localparam bit BOOST = 1'b1;
`else
  localparam int SL    = 8;
  localparam bit BOOST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NR-1:0]     valid;
  logic [DB-1:0]     idx  [NR];
  logic [W-1:0]      data [NR];
  logic [NR*DB-1:0]  req_idx;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic [NP-1:0]     wr_mask;
  logic [NP*DB-1:0]  wr_sel;
  logic [NP*W-1:0]   wr_data;
  logic              busy;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_idx[i*DB +: DB] = idx[i];
      req_data[i*W +: W]  = data[i];
    end
  end

  rob_wb_arbiter #(
    .NUM_REQ(NR), .NUM_PORTS(NP), .WIDTH(W), .DEPTH_BITS(DB), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(valid), .req_idx(req_idx), .req_data(req_data),
    .req_ready(req_ready),
    .wr_mask(wr_mask), .wr_sel(wr_sel), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0]    mask;
    logic [NP*DB-1:0] sel;
    logic [NP*W-1:0]  data;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [NP*W-1:0] act,
                     input logic [NP*W-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: builds the scan order as a list, grants greedily.
  int               m_rr = 0;
  int               m_wait [NR];
  logic [NP*DB-1:0] m_sel  = '0;
  logic [NP*W-1:0]  m_data = '0;

  initial for (int i = 0; i < NR; i++) m_wait[i] = 0;

  always @(negedge clk) begin : model
    int            scan[$];
    int            grants[$];
    logic [DB-1:0] used[$];
    logic [NR-1:0] exp_rdy;
    exp_t          e;
    int            r;
    bit            hit;

    exp_rdy = '0;
    e.mask  = '0;
    e.busy  = 1'b0;
    if (rst) begin
      m_rr   = 0;
      m_sel  = '0;
      m_data = '0;
      for (int i = 0; i < NR; i++) m_wait[i] = 0;
    end else if (flush) begin
      for (int i = 0; i < NR; i++) m_wait[i] = 0;
    end else begin
      scan = {};
      grants = {};
      used = {};
      if (BOOST)
        for (int j = 0; j < NR; j++) begin
          r = (m_rr + j) % NR;
          if (valid[r] && m_wait[r] == SL) scan.push_back(r);
        end
      for (int j = 0; j < NR; j++) begin
        r = (m_rr + j) % NR;
        if (valid[r] && !(BOOST && m_wait[r] == SL)) scan.push_back(r);
      end
      foreach (scan[x]) begin
        hit = 1'b0;
        foreach (used[u]) if (used[u] == idx[scan[x]]) hit = 1'b1;
        if (grants.size() < NP && !hit) begin
          grants.push_back(scan[x]);
          used.push_back(idx[scan[x]]);
        end
      end
      foreach (grants[k]) begin
        e.mask[k]          = 1'b1;
        m_sel[k*DB +: DB]  = idx[grants[k]];
        m_data[k*W +: W]   = data[grants[k]];
        exp_rdy[grants[k]] = 1'b1;
      end
      e.busy = |(valid & ~exp_rdy);
      if (grants.size() > 0) m_rr = (grants[grants.size()-1] + 1) % NR;
      for (int i = 0; i < NR; i++)
        if (exp_rdy[i]) m_wait[i] = 0;
        else if (valid[i] && m_wait[i] < SL) m_wait[i]++;
    end
    e.sel  = m_sel;
    e.data = m_data;
    chk("req_ready", req_ready, exp_rdy);
    exp_q.push_back(e);
  end

  // Monitor: registered outputs after each active edge against the model.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_mask", wr_mask, e.mask);
        chk("wr_sel",  wr_sel,  e.sel);
        chk("wr_data", wr_data, e.data);
        chk("busy",    busy,    e.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_distinct();
    valid = '1;
    for (int i = 0; i < NR; i++) begin
      idx[i]  = DB'(i);
      data[i] = $urandom;
    end
  endtask

  initial begin : driver
    logic [NR-1:0] rdy_seen;
    bit            got;

    rst   = 1'b1;
    flush = 1'b0;
    set_all_distinct();

    // reset held two cycles with every requester valid
    @(negedge clk); chk("rst_ready0", req_ready, '0);
    @(negedge clk); chk("rst_ready1", req_ready, '0); chk("rst_mask", wr_mask, '0);
    tick(); rst = 1'b0;
    @(negedge clk); chk("rr_c1", req_ready, 6'b001111); chk("post_rst_mask", wr_mask, '0);
    tick(); @(negedge clk); chk("rr_c2", req_ready, 6'b110011);
    tick(); @(negedge clk); chk("rr_c3", req_ready, 6'b111100);

    // same-entry conflict, rr_ptr back at 0
    tick(); valid = 6'b000110; idx[1] = 4'd5; idx[2] = 4'd5;
    @(negedge clk); chk("conf_grant", req_ready, 6'b000010);
    tick(); valid = 6'b000100;
    @(negedge clk); chk("conf_next", req_ready, 6'b000100);
    chk("conf_mask", wr_mask, 4'b0001); chk("conf_sel0", wr_sel[DB-1:0], 4'd5);

    // move rr_ptr to 5, then wrap
    tick(); valid = 6'b011000; idx[3] = 4'd3; idx[4] = 4'd4;
    @(negedge clk); chk("pre_wrap", req_ready, 6'b011000);
    tick(); valid = 6'b100001; idx[5] = 4'd5; idx[0] = 4'd0;
    @(negedge clk); chk("wrap_grant", req_ready, 6'b100001);
    tick(); set_all_distinct();
    @(negedge clk); chk("wrap_mask", wr_mask, 4'b0011);
    chk("wrap_sel", wr_sel[2*DB-1:0], 8'h05); chk("after_wrap", req_ready, 6'b011110);

    // flush: registered write still visible, then nothing issued
    tick(); flush = 1'b1;
    @(negedge clk); chk("flush_ready", req_ready, '0); chk("flush_prior_mask", wr_mask, 4'b1111);
    tick(); flush = 1'b0;
    @(negedge clk); chk("flush_next_mask", wr_mask, '0); chk("post_flush", req_ready, 6'b100111);

    // requester 5 competing with 0..3, bounded wait for its grant
    tick(); valid = 6'b101111;
    got = 1'b0;
    for (int c = 0; c < 3 && !got; c++) begin
      @(negedge clk);
      if (req_ready[5]) got = 1'b1;
      else tick();
    end
    chk("req5_within_3", got, 1'b1);

    // randomized traffic with hold-until-accepted requesters
    rdy_seen = req_ready;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NR; i++)
        if (!valid[i] || rdy_seen[i]) begin
          valid[i] = ($urandom_range(0, 3) != 0);
          idx[i]   = DB'($urandom_range(0, 7));
          data[i]  = $urandom;
        end
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      rdy_seen = req_ready;
    end

    tick();
    rst   = 1'b0;
    flush = 1'b0;
    valid = '0;
    repeat (3) @(posedge clk);
    #5;
    if (exp_q.size() > 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected at most 1", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
